piccolo128_seq: RTL and testbench

Sequencer for a Piccolo-128 encryption core built around a single-round datapath. It accepts one 128-bit key and then a stream of 64-bit plaintext blocks over valid/ready handshakes. For each block it applies input whitening, iterates the round datapath 31 times while stepping the on-the-fly key schedule, and presents the output-whitened ciphertext on a held valid/ready output.

---
 rtl/piccolo128_seq_pkg.sv | 68 ++++++
 rtl/piccolo128_seq_if.sv | 26 ++
 rtl/piccolo128_round.sv | 57 +++++
 rtl/piccolo128_seq.sv | 116 +++++++++++
 tb/tb_piccolo128_seq.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piccolo128_seq_pkg.sv
// Shared types, constants and key-schedule helpers for the Piccolo-128 sequencer.
// Words are 16 bits; key and schedule registers hold eight words, word 0 leftmost.
package piccolo128_seq_pkg;

    localparam int NR_ROUNDS = 31;
    localparam int WORD_W    = 16;
    localparam int BYTE_W    = 8;
    localparam int KEY_WORDS = 8;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [0:KEY_WORDS-1] ks_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        ks_t   ks;
        word_t rk0;
        word_t rk1;
    } ks_out_t;

    function automatic word_t wk0(input ks_t k);
        return {k[0][15:8], k[1][7:0]};
    endfunction

    function automatic word_t wk1(input ks_t k);
        return {k[1][15:8], k[0][7:0]};
    endfunction

    function automatic word_t wk2(input ks_t k);
        return {k[4][15:8], k[7][7:0]};
    endfunction

    function automatic word_t wk3(input ks_t k);
        return {k[7][15:8], k[4][7:0]};
    endfunction

    // Constant pair {con(2i), con(2i+1)} for pair index i.
    function automatic logic [31:0] con(input logic [4:0] i);
        logic [4:0] c;
        c = i + 5'd1;
        return {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h6547_a98b;
    endfunction

    // Round rnd uses pair index rnd-1; the word shuffle precedes every pair with (2*rnd) mod 8 == 0.
    function automatic ks_out_t ks_step(input ks_t ks, input logic [4:0] rnd);
        ks_out_t     res;
        ks_t         k;
        logic [2:0]  idx0;
        logic [2:0]  idx1;
        logic [31:0] cv;
        k = ks;
        if (rnd[1:0] == 2'b00) begin
            k = {ks[2], ks[1], ks[6], ks[7], ks[0], ks[3], ks[4], ks[5]};
        end
        idx0    = {rnd[1:0], 1'b0};
        idx1    = {rnd[1:0], 1'b1};
        cv      = con(rnd - 5'd1);
        res.ks  = k;
        res.rk0 = k[idx0] ^ cv[31:16];
        res.rk1 = k[idx1] ^ cv[15:0];
        return res;
    endfunction

endpackage

// File: rtl/piccolo128_seq_if.sv
// Handshake bundle between the Piccolo-128 sequencer and its environment.
interface piccolo128_seq_if;

    logic          key_valid;
    logic          key_ready;
    logic [0:127]  key;
    logic          in_valid;
    logic          in_ready;
    logic [0:63]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [0:63]   out_data;
    logic          busy;
    logic          key_loaded;

    modport slave (
        input  key_valid, key, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data, busy, key_loaded
    );

    modport master (
        output key_valid, key, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data, busy, key_loaded
    );

endinterface

// File: rtl/piccolo128_round.sv
// One combinational Piccolo round: two F-function branches and the optional byte permutation.
module piccolo128_round
    import piccolo128_seq_pkg::*;
(
    input  logic [0:63] state,
    input  word_t       rk0,
    input  word_t       rk1,
    input  logic        last,
    output logic [0:63] next_state
);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
            4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
            4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
            4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  default: y = 4'hd;
        endcase
        return y;
    endfunction

    // Doubling in GF(2^4) modulo x^4 + x + 1.
    function automatic logic [3:0] mul2(input logic [3:0] x);
        return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic word_t f_func(input word_t x);
        logic [3:0] s0, s1, s2, s3;
        logic [3:0] y0, y1, y2, y3;
        s0 = sbox(x[15:12]);
        s1 = sbox(x[11:8]);
        s2 = sbox(x[7:4]);
        s3 = sbox(x[3:0]);
        y0 = mul2(s0) ^ mul2(s1) ^ s1 ^ s2 ^ s3;
        y1 = s0 ^ mul2(s1) ^ mul2(s2) ^ s2 ^ s3;
        y2 = s0 ^ s1 ^ mul2(s2) ^ mul2(s3) ^ s3;
        y3 = mul2(s0) ^ s0 ^ s1 ^ s2 ^ mul2(s3);
        return {sbox(y0), sbox(y1), sbox(y2), sbox(y3)};
    endfunction

    logic [0:63] mixed;

    always_comb begin
        mixed[0:15]  = state[0:15];
        mixed[16:31] = state[16:31] ^ f_func(state[0:15]) ^ rk0;
        mixed[32:47] = state[32:47];
        mixed[48:63] = state[48:63] ^ f_func(state[32:47]) ^ rk1;
        if (last) begin
            next_state = mixed;
        end else begin
            next_state = {mixed[16:23], mixed[56:63], mixed[32:39], mixed[8:15],
                          mixed[48:55], mixed[24:31], mixed[0:7],   mixed[40:47]};
        end
    end

endmodule

// File: rtl/piccolo128_seq.sv
// Piccolo-128 block sequencer: key/plaintext intake, 31 iterations of one round, whitened output.
module piccolo128_seq
    import piccolo128_seq_pkg::*;
#(
    parameter int NR = NR_ROUNDS
)
(
    input  logic           clk,
    input  logic           reset,
    piccolo128_seq_if.slave bus
);

    localparam logic [4:0] LAST_RND = 5'(NR);

    seq_state_e  state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    ks_t         ks_q, ks_d;
    ks_t         mkey_q, mkey_d;
    logic [0:63] data_q, data_d;
    logic        key_loaded_q, key_loaded_d;

    ks_out_t     ks_res;
    logic [0:63] round_out;
    logic        key_ready, in_ready, out_valid, busy;
    logic [0:63] out_data;

    assign ks_res = ks_step(ks_q, rnd_q);

    piccolo128_round u_round (
        .state      (data_q),
        .rk0        (ks_res.rk0),
        .rk1        (ks_res.rk1),
        .last       (rnd_q == LAST_RND),
        .next_state (round_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rnd_q        <= '0;
            ks_q         <= '0;
            mkey_q       <= '0;
            data_q       <= '0;
            key_loaded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            ks_q         <= ks_d;
            mkey_q       <= mkey_d;
            data_q       <= data_d;
            key_loaded_q <= key_loaded_d;
        end
    end

    // A key offer in IDLE always takes priority over a simultaneous plaintext offer.
    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        ks_d         = ks_q;
        mkey_d       = mkey_q;
        data_d       = data_q;
        key_loaded_d = key_loaded_q;
        key_ready    = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        busy         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready = 1'b1;
                in_ready  = key_loaded_q && !bus.key_valid;
                if (bus.key_valid) begin
                    mkey_d       = bus.key;
                    key_loaded_d = 1'b1;
                end else if (bus.in_valid && in_ready) begin
                    data_d  = {bus.in_data[0:15]  ^ wk0(mkey_q), bus.in_data[16:31],
                               bus.in_data[32:47] ^ wk1(mkey_q), bus.in_data[48:63]};
                    rnd_d   = 5'd1;
                    ks_d    = mkey_q;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                data_d = round_out;
                ks_d   = ks_res.ks;
                if (rnd_q == LAST_RND) begin
                    state_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = {data_q[0:15]  ^ wk2(mkey_q), data_q[16:31],
                             data_q[32:47] ^ wk3(mkey_q), data_q[48:63]};
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                    rnd_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.key_ready  = key_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.busy       = busy;
    assign bus.key_loaded = key_loaded_q;

endmodule

// File: tb/tb_piccolo128_seq.sv
// Directed bench for piccolo128_seq with a scoreboard fed by an independent Piccolo-128 model.
module tb_piccolo128_seq;

    logic clk;
    logic reset;

    piccolo128_seq_if bus ();

    piccolo128_seq #(.NR(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [63:0]  PT_A  = 64'h0123456789abcdef;

    logic [63:0]  exp_q[$];
    int           accept_cyc[$];
    logic [127:0] model_key;
    int           cyc;
    int           n_checks;
    int           n_errors;
    int           n_accepts;

    function automatic logic [3:0] tb_sbox(input logic [3:0] x);
        logic [63:0] t;
        t = 64'he4b2_3809_1a7f_6c5d;
        return t[63-4*int'(x) -: 4];
    endfunction

    function automatic logic [3:0] tb_gmul(input logic [3:0] a_in, input logic [3:0] b_in);
        logic [3:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 4'h0;
        for (int n = 0; n < 4; n++) begin
            if (b[0]) p = p ^ a;
            hi = a[3];
            a  = {a[2:0], 1'b0};
            if (hi) a = a ^ 4'h3;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [15:0] tb_f(input logic [15:0] x);
        int         m [4][4];
        logic [3:0] s [4];
        logic [3:0] y [4];
        m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
        for (int j = 0; j < 4; j++) s[j] = tb_sbox(x[15-4*j -: 4]);
        for (int r = 0; r < 4; r++) begin
            y[r] = 4'h0;
            for (int c = 0; c < 4; c++) y[r] = y[r] ^ tb_gmul(4'(m[r][c]), s[c]);
        end
        return {tb_sbox(y[0]), tb_sbox(y[1]), tb_sbox(y[2]), tb_sbox(y[3])};
    endfunction

    function automatic logic [63:0] tb_encrypt(input logic [127:0] key, input logic [63:0] pt);
        logic [15:0] k [8];
        logic [15:0] t [8];
        logic [15:0] rk [62];
        logic [15:0] x [4];
        logic [15:0] w0, w1, w2, w3;
        logic [7:0]  b [8];
        logic [63:0] v;
        logic [4:0]  cc;
        logic [31:0] cv;
        for (int j = 0; j < 8; j++) k[j] = key[127-16*j -: 16];
        w0 = {k[0][15:8], k[1][7:0]};
        w1 = {k[1][15:8], k[0][7:0]};
        w2 = {k[4][15:8], k[7][7:0]};
        w3 = {k[7][15:8], k[4][7:0]};
        for (int i = 0; i < 62; i++) begin
            if ((i + 2) % 8 == 0) begin
                for (int j = 0; j < 8; j++) t[j] = k[j];
                k[0] = t[2]; k[1] = t[1]; k[2] = t[6]; k[3] = t[7];
                k[4] = t[0]; k[5] = t[3]; k[6] = t[4]; k[7] = t[5];
            end
            cc = 5'((i / 2) + 1);
            cv = {cc, 5'b0, cc, 2'b0, cc, 5'b0, cc} ^ 32'h6547a98b;
            rk[i] = k[(i + 2) % 8] ^ ((i % 2 == 0) ? cv[31:16] : cv[15:0]);
        end
        for (int j = 0; j < 4; j++) x[j] = pt[63-16*j -: 16];
        x[0] = x[0] ^ w0;
        x[2] = x[2] ^ w1;
        for (int r = 0; r < 31; r++) begin
            x[1] = x[1] ^ tb_f(x[0]) ^ rk[2*r];
            x[3] = x[3] ^ tb_f(x[2]) ^ rk[2*r+1];
            if (r < 30) begin
                v = {x[0], x[1], x[2], x[3]};
                for (int j = 0; j < 8; j++) b[j] = v[63-8*j -: 8];
                v = {b[2], b[7], b[4], b[1], b[6], b[3], b[0], b[5]};
                for (int j = 0; j < 4; j++) x[j] = v[63-16*j -: 16];
            end
        end
        return {x[0] ^ w2, x[1], x[2] ^ w3, x[3]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic kv, input logic [127:0] k, input logic iv,
                                 input logic [63:0] d, input logic ordy);
        bus.key_valid = kv;
        bus.key       = k;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    // Advance one clock; handshakes are decided from values sampled just before the edge.
    task automatic tick();
        logic         ai, ao, ak;
        logic [63:0]  od, id, e;
        logic [127:0] kd;
        ai = bus.in_valid && bus.in_ready;
        ao = bus.out_valid && bus.out_ready;
        ak = bus.key_valid && bus.key_ready;
        od = bus.out_data;
        id = bus.in_data;
        kd = bus.key;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ai) begin
            exp_q.push_back(tb_encrypt(model_key, id));
            accept_cyc.push_back(cyc);
            n_accepts++;
        end
        if (ak) model_key = kd;
        if (ao) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("ciphertext", od, e);
            end
        end
    endtask

    task automatic waitOutValid(input string tag, output int waited);
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            tick();
            waited++;
        end
        if (!bus.out_valid) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           n;
        int           a0, gap;
        logic [63:0]  held;
        int           seen;
        logic [63:0]  pts [4];

        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        n_accepts = 0;
        model_key = '0;
        reset     = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        checkOutput("rst_key_ready",  64'(bus.key_ready),  64'd1);
        checkOutput("rst_in_ready",   64'(bus.in_ready),   64'd0);
        checkOutput("rst_out_valid",  64'(bus.out_valid),  64'd0);
        checkOutput("rst_busy",       64'(bus.busy),       64'd0);
        checkOutput("rst_key_loaded", 64'(bus.key_loaded), 64'd0);
        checkOutput("rst_out_data",   64'(bus.out_data),   64'd0);

        reset = 1'b1;
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("nokey_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        checkOutput("nokey_no_accept", 64'(n_accepts), 64'd0);
        checkOutput("nokey_busy", 64'(bus.busy), 64'd0);

        $display("[TB] load key and measure latency");
        applyStimulus(1'b1, KEY_A, 1'b0, PT_A, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, PT_A, 1'b1);
        checkOutput("key_loaded", 64'(bus.key_loaded), 64'd1);
        checkOutput("in_ready_after_key", 64'(bus.in_ready), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("accepted", 64'(n_accepts), 64'd1);
        checkOutput("run_busy", 64'(bus.busy), 64'd1);
        checkOutput("run_key_ready", 64'(bus.key_ready), 64'd0);
        checkOutput("run_in_ready", 64'(bus.in_ready), 64'd0);
        waitOutValid("latency", n);
        checkOutput("latency", 64'(n), 64'd31);
        tick();
        checkOutput("out_valid_dropped", 64'(bus.out_valid), 64'd0);
        checkOutput("idle_busy", 64'(bus.busy), 64'd0);
        checkOutput("queue_drained_1", 64'(exp_q.size()), 64'd0);

        $display("[TB] output stall for 10 cycles");
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        waitOutValid("stall", n);
        held = bus.out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stall_data", bus.out_data, held);
        end
        checkOutput("stall_queue_pending", 64'(exp_q.size()), 64'd1);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        checkOutput("stall_released", 64'(bus.out_valid), 64'd0);
        checkOutput("queue_drained_2", 64'(exp_q.size()), 64'd0);

        $display("[TB] back-to-back blocks");
        pts[0] = 64'hfedcba9876543210;
        pts[1] = 64'h0000000000000000;
        pts[2] = 64'hffffffffffffffff;
        pts[3] = 64'h5a5a5a5aa5a5a5a5;
        accept_cyc.delete();
        a0 = n_accepts;
        applyStimulus(1'b0, '0, 1'b1, pts[0], 1'b1);
        n = 0;
        while ((n_accepts - a0 < 4 || exp_q.size() != 0 || bus.out_valid) && n < 400) begin
            tick();
            n++;
            if (n_accepts - a0 >= 4) bus.in_valid = 1'b0;
            else bus.in_data = pts[n_accepts - a0];
        end
        checkOutput("b2b_accepts", 64'(n_accepts - a0), 64'd4);
        for (int i = 1; i < 4; i++) begin
            gap = (i < accept_cyc.size()) ? accept_cyc[i] - accept_cyc[i-1] : -1;
            checkOutput("b2b_gap", 64'(gap), 64'd33);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);

        $display("[TB] key and block offered together");
        applyStimulus(1'b1, KEY_B, 1'b1, PT_A, 1'b1);
        checkOutput("collide_in_ready", 64'(bus.in_ready), 64'd0);
        a0 = n_accepts;
        tick();
        checkOutput("collide_no_accept", 64'(n_accepts - a0), 64'd0);
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b1);
        checkOutput("collide_in_ready_next", 64'(bus.in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("collide_accept_next", 64'(n_accepts - a0), 64'd1);
        waitOutValid("collide", n);
        tick();
        checkOutput("queue_drained_3", 64'(exp_q.size()), 64'd0);

        $display("[TB] reset during RUN");
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 14; i++) tick();
        reset = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("abort_key_loaded", 64'(bus.key_loaded), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("abort_key_ready", 64'(bus.key_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        checkOutput("abort_no_output", 64'(seen), 64'd0);
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd0);
        applyStimulus(1'b1, KEY_A, 1'b0, '0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b1, PT_A, 1'b1);
        tick();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        waitOutValid("reload", n);
        checkOutput("reload_latency", 64'(n), 64'd31);
        tick();
        checkOutput("queue_drained_4", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
